// File: rtl/ss.sv
// Store-size merge unit: splices the low byte/halfword/word of register B into the MDR word.
// Define SS_REG_OUT_EN for registered outputs (async active-low reset); the default build is combinational.
module ss (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  RegSSControl,
  input  logic [31:0] RegBOut,
  input  logic [31:0] RegMDROut,
  output logic [31:0] SSControlOut,
  output logic [3:0]  SSByteEn,
  output logic        SSIllegal,
  output logic        SSValid
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [31:0] data_next;
  logic [3:0]  byte_en_next;
  logic        illegal_next;

  // Anything other than a recognised size (including X/Z) falls to the illegal case.
  always_comb begin
    byte_en_next = 4'b0000;
    illegal_next = 1'b1;
    case (RegSSControl)
      SIZE_BYTE: begin
        byte_en_next = 4'b0001;
        illegal_next = 1'b0;
      end
      SIZE_HALF: begin
        byte_en_next = 4'b0011;
        illegal_next = 1'b0;
      end
      SIZE_WORD: begin
        byte_en_next = 4'b1111;
        illegal_next = 1'b0;
      end
      default: begin
        byte_en_next = 4'b0000;
        illegal_next = 1'b1;
      end
    endcase
  end

  // Each lane is a plain mux between B and MDR, so untouched lanes keep the old memory bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign data_next[8*gi +: 8] = byte_en_next[gi] ? RegBOut[8*gi +: 8]
                                                     : RegMDROut[8*gi +: 8];
    end
  endgenerate

`ifdef SS_REG_OUT_EN
  logic [31:0] data_reg;
  logic [3:0]  byte_en_reg;
  logic        illegal_reg;
  logic        valid_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg    <= 32'h0000_0000;
      byte_en_reg <= 4'b0000;
      illegal_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      data_reg    <= data_next;
      byte_en_reg <= byte_en_next;
      illegal_reg <= illegal_next;
      valid_reg   <= 1'b1;
    end
  end

  assign SSControlOut = data_reg;
  assign SSByteEn     = byte_en_reg;
  assign SSIllegal    = illegal_reg;
  assign SSValid      = valid_reg;
`else
  // Clock and reset have no role in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset_n;

  assign SSControlOut = data_next;
  assign SSByteEn     = byte_en_next;
  assign SSIllegal    = illegal_next;
  assign SSValid      = 1'b1;
`endif

endmodule

// File: tb/tb_ss.sv
// Directed table-driven bench for ss; covers both the combinational and the SS_REG_OUT_EN builds.
module tb_ss;

  logic        clk;
  logic        reset_n;
  logic [1:0]  RegSSControl;
  logic [31:0] RegBOut;
  logic [31:0] RegMDROut;
  logic [31:0] SSControlOut;
  logic [3:0]  SSByteEn;
  logic        SSIllegal;
  logic        SSValid;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] b;
    logic [31:0] mdr;
    logic [31:0] exp_out;
    logic [3:0]  exp_be;
    logic        exp_ill;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  ss dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .RegSSControl (RegSSControl),
    .RegBOut      (RegBOut),
    .RegMDROut    (RegMDROut),
    .SSControlOut (SSControlOut),
    .SSByteEn     (SSByteEn),
    .SSIllegal    (SSIllegal),
    .SSValid      (SSValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v, input logic exp_valid);
    check({tag, " out"},   SSControlOut, v.exp_out);
    check({tag, " be"},    {28'd0, SSByteEn}, {28'd0, v.exp_be});
    check({tag, " ill"},   {31'd0, SSIllegal}, {31'd0, v.exp_ill});
    check({tag, " valid"}, {31'd0, SSValid}, {31'd0, exp_valid});
    $display("%s code=%b B=%08h MDR=%08h -> out=%08h be=%b ill=%b valid=%b",
             tag, v.code, v.b, v.mdr, SSControlOut, SSByteEn, SSIllegal, SSValid);
  endtask

  task automatic drive(input vec_t v);
    RegSSControl = v.code;
    RegBOut      = v.b;
    RegMDROut    = v.mdr;
  endtask

  vec_t zero_v;
  vec_t prev_v;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{2'b00, 32'h1234_5678, 32'hAABB_CCDD, 32'hAABB_CC78, 4'b0001, 1'b0};
    vecs[1]  = '{2'b01, 32'h1234_5678, 32'hAABB_CCDD, 32'hAABB_5678, 4'b0011, 1'b0};
    vecs[2]  = '{2'b10, 32'h1234_5678, 32'hAABB_CCDD, 32'h1234_5678, 4'b1111, 1'b0};
    vecs[3]  = '{2'b11, 32'h1234_5678, 32'hAABB_CCDD, 32'hAABB_CCDD, 4'b0000, 1'b1};
    vecs[4]  = '{2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF00, 4'b0001, 1'b0};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b0};
    vecs[6]  = '{2'b01, 32'h0000_8001, 32'h0000_0000, 32'h0000_8001, 4'b0011, 1'b0};
    vecs[7]  = '{2'b00, 32'h0000_0080, 32'h0000_0000, 32'h0000_0080, 4'b0001, 1'b0};
    vecs[8]  = '{2'b01, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0123_BEEF, 4'b0011, 1'b0};
    vecs[9]  = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[10] = '{2'b00, 32'hFFFF_FF5A, 32'h0000_0000, 32'h0000_005A, 4'b0001, 1'b0};
    zero_v   = '{2'b00, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0};

    // Reset held from time zero, first vector applied underneath it.
    reset_n = 1'b0;
    drive(vecs[0]);
    #2;
`ifdef SS_REG_OUT_EN
    check_vec("reset", zero_v, 1'b0);
`else
    check_vec("reset", vecs[0], 1'b1);
`endif

    // Release between edges; registered outputs wait for the next rising edge.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
`ifdef SS_REG_OUT_EN
    check_vec("release", zero_v, 1'b0);
    @(posedge clk);
    #1;
`endif
    check_vec("first", vecs[0], 1'b1);
    prev_v = vecs[0];

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
`ifdef SS_REG_OUT_EN
      check_vec($sformatf("hold%0d", i), prev_v, 1'b1);
      @(posedge clk);
      #1;
`endif
      check_vec($sformatf("vec%0d", i), vecs[i], 1'b1);
      prev_v = vecs[i];
    end

    // Reset asserted mid-cycle after a new input has been captured.
    @(negedge clk);
    drive(vecs[1]);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
`ifdef SS_REG_OUT_EN
    check_vec("midrst", zero_v, 1'b0);
`else
    check_vec("midrst", vecs[1], 1'b1);
`endif
    #1;
    reset_n = 1'b1;
    #1;
`ifdef SS_REG_OUT_EN
    check_vec("midrel", zero_v, 1'b0);
    @(posedge clk);
    #1;
`endif
    check_vec("after", vecs[1], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss.md
SS -- requirements
Module: ss

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port reset_n  input  1  asynchronous active-low reset.
REQ-004 Port RegSSControl  input  2  store size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-005 Port RegBOut  input  32  new data from register B.
REQ-006 Port RegMDROut  input  32  old memory word from the MDR.
REQ-007 Port SSControlOut  output  32  merged word to write to memory.
REQ-008 Port SSByteEn  output  4  byte lanes replaced by the store; bit i = byte i.
REQ-009 Port SSIllegal  output  1  high when RegSSControl = 11.
REQ-010 Port SSValid  output  1  high when the outputs hold a valid merge result.

Function
REQ-011 Code 00 SHALL give SSControlOut = {RegMDROut[31:8], RegBOut[7:0]} and SSByteEn = 0001.
REQ-012 Code 01 SHALL give SSControlOut = {RegMDROut[31:16], RegBOut[15:0]} and SSByteEn = 0011.
REQ-013 Code 10 SHALL give SSControlOut = RegBOut and SSByteEn = 1111.
REQ-014 Code 11 SHALL give SSControlOut = RegMDROut unchanged, SSByteEn = 0000 and SSIllegal = 1.
REQ-015 SSIllegal SHALL be 0 for codes 00, 01 and 10.
REQ-016 The merge SHALL be pure bit selection: no sign or zero extension, no arithmetic.
REQ-017 Upper MDR bits SHALL pass through untouched in byte and halfword modes.
REQ-018 An X or Z on RegSSControl SHALL resolve to the code-11 behaviour.

Reset
REQ-019 In registered mode, reset_n = 0 SHALL immediately force SSControlOut = 0, SSByteEn = 0000, SSIllegal = 0 and SSValid = 0, without waiting for a clock edge.
REQ-020 In registered mode, SSValid SHALL become 1 at the first rising clk edge after reset_n rises and stay 1 until the next reset.
REQ-021 If reset is asserted mid-operation, the outputs SHALL clear at once and the pending result SHALL be discarded.
REQ-022 In combinational mode, the outputs SHALL ignore clk and reset_n, and SSValid SHALL be constant 1.

Configuration
REQ-023 Macro SS_REG_OUT_EN SHALL select the output mode.
- Defined: all outputs are registered on the rising clk edge, with 1-cycle latency from any input change.
- Undefined (default): all outputs are combinational, with 0-cycle latency.
REQ-024 Merge results SHALL be identical in both modes; only timing and reset behaviour SHALL differ.

Verification
REQ-025 B=12345678, MDR=AABBCCDD, code 00 -> SSControlOut=AABBCC78, SSByteEn=0001.
REQ-026 Same data, code 01 -> AABB5678, SSByteEn=0011; code 10 -> 12345678, SSByteEn=1111.
REQ-027 B=00000000, MDR=FFFFFFFF, code 00 -> FFFFFF00; B=FFFFFFFF, MDR=00000000, code 10 -> FFFFFFFF.
REQ-028 Code 11 with MDR=AABBCCDD -> SSControlOut=AABBCCDD, SSByteEn=0000, SSIllegal=1.
REQ-029 With SS_REG_OUT_EN defined, an input change SHALL appear on the outputs exactly one clk edge later.
REQ-030 With SS_REG_OUT_EN defined, asserting reset_n low between clock edges SHALL clear all outputs immediately; after release, SSValid SHALL rise at the next edge.
